// File: rtl/chess_pkg.sv
// Shared chess types: piece codes, square encoding, move-controller states
// and the colour-ownership test used when a piece is clicked.
package chess_pkg;

  localparam logic [3:0] EMPTY    = 4'd0;
  localparam logic [3:0] W_PAWN   = 4'd1;
  localparam logic [3:0] W_KNIGHT = 4'd2;
  localparam logic [3:0] W_BISHOP = 4'd3;
  localparam logic [3:0] W_ROOK   = 4'd4;
  localparam logic [3:0] W_QUEEN  = 4'd5;
  localparam logic [3:0] W_KING   = 4'd6;
  localparam logic [3:0] B_PAWN   = 4'd7;
  localparam logic [3:0] B_KNIGHT = 4'd8;
  localparam logic [3:0] B_BISHOP = 4'd9;
  localparam logic [3:0] B_ROOK   = 4'd10;
  localparam logic [3:0] B_QUEEN  = 4'd11;
  localparam logic [3:0] B_KING   = 4'd12;
  localparam logic [3:0] MARK     = 4'd13;

  // {row[2:0], col[2:0]}
  typedef logic [5:0] square_t;

  typedef enum logic [2:0] {IDLE, CHECK, PICK, HOLD, PLACE} mc_state_t;

  function automatic logic is_own(input logic [3:0] code, input logic turn);
    if (turn)
      return (code >= B_PAWN) && (code <= B_KING);
    else
      return (code >= W_PAWN) && (code <= W_KING);
  endfunction

endpackage

// File: rtl/mouse_to_square.sv
// Registered pixel-to-square decode. Off the board the last square is kept
// and cursor_valid drops.
module mouse_to_square
  import chess_pkg::*;
#(
  parameter int BOARD_X = 256,
  parameter int BOARD_Y = 128,
  parameter int SQ_LOG2 = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] mouse_x,
  input  logic [11:0] mouse_y,
  output square_t     cursor_xy,
  output logic        cursor_valid
);

  localparam int SPAN = 8 << SQ_LOG2;

  logic [12:0] dx, dy;
  logic        on_x, on_y;

  // One extra bit so the >= test and the wrapped difference never alias.
  assign dx   = {1'b0, mouse_x} - 13'(BOARD_X);
  assign dy   = {1'b0, mouse_y} - 13'(BOARD_Y);
  assign on_x = ({1'b0, mouse_x} >= 13'(BOARD_X)) && (dx < 13'(SPAN));
  assign on_y = ({1'b0, mouse_y} >= 13'(BOARD_Y)) && (dy < 13'(SPAN));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cursor_xy    <= '0;
      cursor_valid <= 1'b0;
    end else begin
      cursor_valid <= on_x && on_y;
      if (on_x && on_y)
        cursor_xy <= {dy[SQ_LOG2 +: 3], dx[SQ_LOG2 +: 3]};
    end
  end

endmodule

// File: rtl/move_controller.sv
// Turns mouse clicks into chess_board pick/place commands and tracks whose
// turn it is. State is exported on dbg_state.
module move_controller
  import chess_pkg::*;
#(
  parameter int BOARD_X  = 256,
  parameter int BOARD_Y  = 128,
  parameter int SQ_LOG2  = 6,
  parameter int CODE_LAT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] mouse_x,
  input  logic [11:0] mouse_y,
  input  logic        mouse_left,
  input  logic        mouse_right,
  input  logic [3:0]  figure_code,
  input  logic [63:0] possible_moves,
  input  square_t     pp_pos,
  output square_t     cursor_xy,
  output logic        cursor_valid,
  output square_t     figure_position,
  output logic        pick_piece,
  output logic        place_piece,
  output logic        holding,
  output logic        turn,
  output logic        move_done,
  output mc_state_t   dbg_state
);

  mc_state_t state, next_state;
  square_t   dec_xy, click_xy, dest;
  logic      left_d, right_d, left_edge, right_edge;
  logic      cancel, accept;
  logic [3:0] cnt;

  mouse_to_square #(
    .BOARD_X(BOARD_X),
    .BOARD_Y(BOARD_Y),
    .SQ_LOG2(SQ_LOG2)
  ) u_decode (
    .clk         (clk),
    .rst         (rst),
    .mouse_x     (mouse_x),
    .mouse_y     (mouse_y),
    .cursor_xy   (dec_xy),
    .cursor_valid(cursor_valid)
  );

  // While checking, the board must look at the clicked square, not the live cursor.
  assign cursor_xy  = (state == CHECK) ? click_xy : dec_xy;
  assign left_edge  = mouse_left & ~left_d;
  assign right_edge = mouse_right & ~right_d;
  assign cancel     = right_edge || (left_edge && cursor_valid && (cursor_xy == pp_pos));
  assign accept     = left_edge && cursor_valid && possible_moves[cursor_xy];
  assign dest       = cancel ? pp_pos : cursor_xy;
  assign dbg_state  = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (left_edge && cursor_valid) next_state = CHECK;
      CHECK:   if (cnt == 4'd0) next_state = is_own(figure_code, turn) ? PICK : IDLE;
      PICK:    next_state = HOLD;
      HOLD:    if (cancel || accept) next_state = PLACE;
      PLACE:   next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    pick_piece  = (state == PICK);
    place_piece = (state == PLACE);
    holding     = (state == HOLD);
    move_done   = (state == PLACE) && (figure_position != pp_pos);
  end

  // figure_position doubles as the latched destination while in PLACE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      left_d          <= 1'b0;
      right_d         <= 1'b0;
      click_xy        <= '0;
      cnt             <= '0;
      figure_position <= '0;
      turn            <= 1'b0;
    end else begin
      left_d  <= mouse_left;
      right_d <= mouse_right;
      case (state)
        IDLE: if (left_edge && cursor_valid) begin
          click_xy <= cursor_xy;
          cnt      <= 4'(CODE_LAT);
        end
        CHECK: begin
          if (cnt != 4'd0) cnt <= cnt - 4'd1;
          else if (is_own(figure_code, turn)) figure_position <= click_xy;
        end
        HOLD:  if (cancel || accept) figure_position <= dest;
        PLACE: if (figure_position != pp_pos) turn <= ~turn;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_move_controller.sv
// Bench for move_controller: directed clicks from the test list, then random
// clicks, checked against an abstract turn/holding model of the game.
module tb_move_controller;
  import chess_pkg::*;

  localparam int W  = 24;
  localparam int BX = 256;
  localparam int BY = 128;
  localparam int SQ = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [11:0] mouse_x = '0, mouse_y = '0;
  logic        mouse_left = 1'b0, mouse_right = 1'b0;
  logic [3:0]  figure_code;
  logic [63:0] possible_moves = '0;
  logic [5:0]  pp_pos = '0;
  logic [5:0]  cursor_xy, figure_position;
  logic        cursor_valid, pick_piece, place_piece, holding, turn, move_done;
  mc_state_t   dbg_state;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [3:0]   board [64];
  logic [3:0]   fc1;
  logic [W-1:0] exp_q [$];
  logic [W-1:0] obs_q [$];

  bit         m_turn, m_hold;
  logic [5:0] m_pp, m_cur;

  move_controller dut (
    .clk(clk), .rst(rst), .mouse_x(mouse_x), .mouse_y(mouse_y),
    .mouse_left(mouse_left), .mouse_right(mouse_right),
    .figure_code(figure_code), .possible_moves(possible_moves), .pp_pos(pp_pos),
    .cursor_xy(cursor_xy), .cursor_valid(cursor_valid),
    .figure_position(figure_position), .pick_piece(pick_piece),
    .place_piece(place_piece), .holding(holding), .turn(turn),
    .move_done(move_done), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  // chess_board stand-in: figure_code is the board code two cycles after cursor_xy
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      fc1         <= '0;
      figure_code <= '0;
    end else begin
      fc1         <= board[cursor_xy];
      figure_code <= fc1;
    end
  end

  // pulse monitor: {kind, square, cycle}; kind 00 pick, {move_done, place} otherwise
  always begin
    @(posedge clk);
    #2;
    cyc++;
    if (pick_piece)
      obs_q.push_back({2'b00, figure_position, 16'(cyc)});
    if (place_piece || move_done)
      obs_q.push_back({move_done, place_piece, figure_position, 16'(cyc)});
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  function automatic bit on_board(input int x, input int y);
    return (x >= BX) && (x < BX + 8 * SQ) && (y >= BY) && (y < BY + 8 * SQ);
  endfunction

  function automatic logic [5:0] square_of(input int x, input int y);
    return 6'(((y - BY) / SQ) * 8 + (x - BX) / SQ);
  endfunction

  function automatic bit own_piece(input logic [3:0] c, input bit t);
    return t ? (c >= 7 && c <= 12) : (c >= 1 && c <= 6);
  endfunction

  task automatic move_mouse(input int x, input int y);
    @(negedge clk);
    mouse_x = 12'(x);
    mouse_y = 12'(y);
    repeat (2) @(negedge clk);
    if (on_board(x, y)) m_cur = square_of(x, y);
    check_eq("cursor_valid", cursor_valid, on_board(x, y));
    check_eq("cursor_xy", cursor_xy, m_cur);
  endtask

  task automatic click(input int x, input int y, input bit l, input bit r);
    bit v;
    logic [5:0] sq;
    int press;
    move_mouse(x, y);
    v     = on_board(x, y);
    sq    = v ? square_of(x, y) : 6'd0;
    press = cyc;
    if (!m_hold) begin
      if (l && v && own_piece(board[sq], m_turn)) begin
        exp_q.push_back({2'b00, sq, 16'(press + 4)});
        m_hold = 1'b1;
        m_pp   = sq;
        pp_pos = sq;
      end
    end else if (r || (l && v && sq == m_pp)) begin
      exp_q.push_back({2'b01, m_pp, 16'(press + 1)});
      m_hold = 1'b0;
    end else if (l && v && possible_moves[sq]) begin
      exp_q.push_back({2'b11, sq, 16'(press + 1)});
      m_hold = 1'b0;
      m_turn = ~m_turn;
    end
    mouse_left  = l;
    mouse_right = r;
    @(negedge clk);
    mouse_left  = 1'b0;
    mouse_right = 1'b0;
    repeat (8) @(negedge clk);
    check_eq("event_count", obs_q.size(), exp_q.size());
    while (exp_q.size() > 0 && obs_q.size() > 0)
      check_eq("event", obs_q.pop_front(), exp_q.pop_front());
    exp_q.delete();
    obs_q.delete();
    check_eq("holding", holding, m_hold);
    check_eq("turn", turn, m_turn);
    check_eq("state", dbg_state, m_hold ? HOLD : IDLE);
  endtask

  task automatic click_sq(input int s, input bit l, input bit r);
    click(BX + (s % 8) * SQ + $urandom_range(0, SQ - 1),
          BY + (s / 8) * SQ + $urandom_range(0, SQ - 1), l, r);
  endtask

  task automatic clear_board();
    for (int i = 0; i < 64; i++) board[i] = 4'd0;
  endtask

  task automatic check_reset_outputs();
    check_eq("rst_holding", holding, 0);
    check_eq("rst_turn", turn, 0);
    check_eq("rst_pick", pick_piece, 0);
    check_eq("rst_place", place_piece, 0);
    check_eq("rst_move_done", move_done, 0);
    check_eq("rst_cursor_valid", cursor_valid, 0);
    check_eq("rst_cursor_xy", cursor_xy, 0);
    check_eq("rst_figure_position", figure_position, 0);
  endtask

  initial begin
    int x, y, k;
    clear_board();
    m_turn = 0; m_hold = 0; m_pp = '0; m_cur = '0;
    repeat (3) @(negedge clk);
    check_reset_outputs();
    rst = 1'b0;

    // wrong colour, empty and marker squares do not pick for white
    board[0] = 4'd7; board[2] = 4'd13;
    click_sq(0, 1, 0);
    click_sq(1, 1, 0);
    click_sq(2, 1, 0);
    click_sq(3, 0, 1);

    // pick the white pawn on square 52 and move it to 36
    board[52] = 4'd1;
    possible_moves = 64'd1 << 36;
    click(522, 517, 1, 0);
    check_eq("pick_square", figure_position, 52);
    click(522, 389, 1, 0);
    check_eq("place_square", figure_position, 36);

    // off-board and board-edge pixels
    click(100, 50, 1, 0);
    click(767, 639, 1, 0);
    click(768, 639, 1, 0);
    check_eq("edge_cursor_hold", cursor_xy, 63);

    // black: illegal target, right-click cancel, simultaneous, self-click cancel
    board[10] = 4'd7;
    possible_moves = (64'd1 << 18) | (64'd1 << 26);
    click_sq(10, 1, 0);
    click_sq(40, 1, 0);
    click_sq(40, 0, 1);
    click_sq(10, 1, 0);
    click_sq(18, 1, 1);
    click_sq(10, 1, 0);
    click_sq(10, 1, 0);

    // random play
    for (int it = 0; it < 70; it++) begin
      if (!m_hold)
        for (int i = 0; i < 64; i++) board[i] = 4'($urandom_range(0, 13));
      else
        possible_moves = {$urandom, $urandom};
      k = $urandom_range(0, 9);
      if (k < 8) begin
        click_sq($urandom_range(0, 63), k != 7, k >= 6);
      end else begin
        x = $urandom_range(0, 1023);
        y = $urandom_range(0, 767);
        click(x, y, 1'b1, 1'b0);
      end
    end

    // reach HOLD with black to move, then reset mid-hold
    if (m_hold) click_sq(m_pp, 0, 1);
    if (!m_turn) begin
      clear_board();
      board[5] = 4'd1;
      possible_moves = 64'd1 << 13;
      click_sq(5, 1, 0);
      click_sq(13, 1, 0);
    end
    clear_board();
    board[50] = 4'd7;
    click_sq(50, 1, 0);
    check_eq("pre_rst_turn", turn, 1);
    #2;
    rst = 1'b1;
    #1;
    check_eq("mid_rst_holding", holding, 0);
    check_eq("mid_rst_turn", turn, 0);
    check_eq("mid_rst_pick", pick_piece, 0);
    check_eq("mid_rst_place", place_piece, 0);
    check_eq("mid_rst_move_done", move_done, 0);
    @(negedge clk);
    rst = 1'b0;
    m_turn = 0; m_hold = 0; m_cur = '0;
    repeat (2) @(negedge clk);
    obs_q.delete();
    board[52] = 4'd1;
    click(522, 517, 1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
